// File: rtl/e203_exu_brchslv_reg_if.sv
// Commit-to-branch-resolve handshake and IFU redirect bundle for e203_exu_brchslv_reg.
// master = commit stage / IFU side, slave = branch-resolve unit.
interface e203_exu_brchslv_reg_if #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned XLEN = 32
);
  logic            cmt_i_valid;
  logic            cmt_i_ready;
  logic            cmt_i_rv32;
  logic            cmt_i_bjp;
  logic            cmt_i_bjp_prdt;
  logic            cmt_i_bjp_rslv;
  logic            cmt_i_fencei;
  logic            cmt_i_mret;
  logic            cmt_i_dret;
  logic [PC_W-1:0] cmt_i_pc;
  logic [XLEN-1:0] cmt_i_imm;
  logic            brchmis_flush_req;
  logic            brchmis_flush_ack;
  logic [PC_W-1:0] brchmis_flush_pc;
  logic            cmt_mret_ena;
  logic            cmt_dret_ena;
  logic            cmt_fencei_ena;

  modport master (
    output cmt_i_valid, cmt_i_rv32, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
           cmt_i_fencei, cmt_i_mret, cmt_i_dret, cmt_i_pc, cmt_i_imm,
           brchmis_flush_ack,
    input  cmt_i_ready, brchmis_flush_req, brchmis_flush_pc,
           cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena
  );

  modport slave (
    input  cmt_i_valid, cmt_i_rv32, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
           cmt_i_fencei, cmt_i_mret, cmt_i_dret, cmt_i_pc, cmt_i_imm,
           brchmis_flush_ack,
    output cmt_i_ready, brchmis_flush_req, brchmis_flush_pc,
           cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena
  );
endinterface

// File: rtl/e203_exu_brchslv_reg.sv
// Registered branch-resolve unit: captures redirect PC into a one-entry flush buffer
// and holds the flush request until the IFU acks. Perf counters built with E203_BRSLV_PERF_EN.
module e203_exu_brchslv_reg #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_exu_brchslv_reg_if.slave bus,
  input  logic [PC_W-1:0]      csr_epc_r,
  input  logic [PC_W-1:0]      csr_dpc_r,
  input  logic                 nonalu_excpirq_flush_req_raw,
  input  logic                 perf_clr,
  output logic [CNT_W-1:0]     perf_bjp_cnt,
  output logic [CNT_W-1:0]     perf_mis_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t          state;
  logic [PC_W-1:0] flush_pc_r;
  logic            kind_mret;
  logic            kind_dret;
  logic            kind_fencei;

  logic            brch_class;
  logic            need_flush;
  logic            accept;
  logic            flush_req;
  logic            flush_hsk;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] off_pc;
  logic [PC_W-1:0] target;

  always_comb begin
    brch_class = bus.cmt_i_bjp | bus.cmt_i_fencei | bus.cmt_i_mret | bus.cmt_i_dret;
    need_flush = (bus.cmt_i_bjp & (bus.cmt_i_bjp_prdt ^ bus.cmt_i_bjp_rslv))
               | bus.cmt_i_fencei | bus.cmt_i_mret | bus.cmt_i_dret;
    seq_pc     = bus.cmt_i_pc + (bus.cmt_i_rv32 ? PC_W'(4) : PC_W'(2));
    off_pc     = bus.cmt_i_pc + bus.cmt_i_imm[PC_W-1:0];
    if (bus.cmt_i_dret)
      target = csr_dpc_r;
    else if (bus.cmt_i_mret)
      target = csr_epc_r;
    else if (bus.cmt_i_fencei | bus.cmt_i_bjp_prdt)
      target = seq_pc;
    else
      target = off_pc;
  end

  // A pending redirect is only masked by the non-ALU flush, never cancelled by it.
  assign flush_req = (state == PEND) & ~nonalu_excpirq_flush_req_raw;
  assign flush_hsk = flush_req & bus.brchmis_flush_ack;
  assign accept    = bus.cmt_i_valid & bus.cmt_i_ready;

  assign bus.cmt_i_ready       = (state == IDLE) & (~brch_class | ~nonalu_excpirq_flush_req_raw);
  assign bus.brchmis_flush_req = flush_req;
  assign bus.brchmis_flush_pc  = flush_pc_r;
  assign bus.cmt_mret_ena      = flush_hsk & kind_mret;
  assign bus.cmt_dret_ena      = flush_hsk & kind_dret;
  assign bus.cmt_fencei_ena    = flush_hsk & kind_fencei;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_pc_r  <= '0;
      kind_mret   <= 1'b0;
      kind_dret   <= 1'b0;
      kind_fencei <= 1'b0;
    end else if (state == IDLE) begin
      if (accept & need_flush) begin
        state       <= PEND;
        flush_pc_r  <= target;
        kind_mret   <= bus.cmt_i_mret;
        kind_dret   <= bus.cmt_i_dret;
        kind_fencei <= bus.cmt_i_fencei;
      end
    end else if (flush_hsk) begin
      state <= IDLE;
    end
  end

`ifdef E203_BRSLV_PERF_EN
  logic [CNT_W-1:0] bjp_cnt;
  logic [CNT_W-1:0] mis_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      bjp_cnt <= '0;
      mis_cnt <= '0;
    end else if (accept & bus.cmt_i_bjp) begin
      if (bus.cmt_i_bjp_prdt == bus.cmt_i_bjp_rslv) begin
        if (bjp_cnt != '1) bjp_cnt <= bjp_cnt + CNT_W'(1);
      end else begin
        if (mis_cnt != '1) mis_cnt <= mis_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_bjp_cnt = bjp_cnt;
  assign perf_mis_cnt = mis_cnt;
`else
  logic perf_clr_unused;
  assign perf_clr_unused = perf_clr;
  assign perf_bjp_cnt    = '0;
  assign perf_mis_cnt    = '0;
`endif

endmodule

// File: tb/tb_e203_exu_brchslv_reg.sv
// Self-checking bench for e203_exu_brchslv_reg: directed cycle table, perf corner
// sequence, then random stimulus against a transaction-level reference model.
module tb_e203_exu_brchslv_reg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
`ifdef E203_BRSLV_PERF_EN
  localparam bit          PERF  = 1'b1;
`else
  localparam bit          PERF  = 1'b0;
`endif

  // attribute bits: {rv32, bjp, prdt, rslv, fencei, mret, dret}
  localparam logic [6:0] A_NONE   = 7'b0000000;
  localparam logic [6:0] A_ALU    = 7'b1000000;
  localparam logic [6:0] A_BR_MIS = 7'b1101000;
  localparam logic [6:0] A_BR_PMS = 7'b1110000;
  localparam logic [6:0] A_BJP_OK = 7'b1100000;
  localparam logic [6:0] A_FNC16  = 7'b0000100;
  localparam logic [6:0] A_MRET   = 7'b1000010;
  localparam logic [6:0] A_DRET   = 7'b1000001;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [6:0]  attr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] epc;
    logic [31:0] dpc;
    logic        na;
    logic        ack;
    logic        pclr;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_pc;
    logic [2:0]  e_ena;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [PC_W-1:0]  csr_epc_r;
  logic [PC_W-1:0]  csr_dpc_r;
  logic             nonalu;
  logic             perf_clr;
  logic [CNT_W-1:0] perf_bjp_cnt;
  logic [CNT_W-1:0] perf_mis_cnt;

  e203_exu_brchslv_reg_if #(.PC_W(PC_W), .XLEN(XLEN)) bif ();

  e203_exu_brchslv_reg #(.PC_W(PC_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .bus                          (bif),
    .csr_epc_r                    (csr_epc_r),
    .csr_dpc_r                    (csr_dpc_r),
    .nonalu_excpirq_flush_req_raw (nonalu),
    .perf_clr                     (perf_clr),
    .perf_bjp_cnt                 (perf_bjp_cnt),
    .perf_mis_cnt                 (perf_mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;

  // Reference model: a single pending-redirect slot plus two event tallies.
  bit          m_pend;
  logic [31:0] m_fpc;
  logic [2:0]  m_kind;
  int          m_bjp;
  int          m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic vld, logic [6:0] a, logic [31:0] pc, logic [31:0] imm,
                              logic [31:0] epc, logic [31:0] dpc, logic na, logic ack,
                              logic er, logic eq, logic [31:0] efpc, logic [2:0] ena);
    vec_t v;
    v.rst_n = r;   v.valid = vld; v.attr = a;   v.pc = pc;   v.imm = imm;
    v.epc = epc;   v.dpc = dpc;   v.na = na;    v.ack = ack; v.pclr = 1'b0;
    v.e_ready = er; v.e_req = eq; v.e_pc = efpc; v.e_ena = ena;
    return v;
  endfunction

  function automatic logic [31:0] add32(logic [31:0] a, logic [31:0] b);
    longint s;
    s = (longint'(a) + longint'(b)) % 64'sh1_0000_0000;
    return s[31:0];
  endfunction

  task automatic drive(input vec_t v);
    rst_n                 = v.rst_n;
    bif.cmt_i_valid       = v.valid;
    {bif.cmt_i_rv32, bif.cmt_i_bjp, bif.cmt_i_bjp_prdt, bif.cmt_i_bjp_rslv,
     bif.cmt_i_fencei, bif.cmt_i_mret, bif.cmt_i_dret} = v.attr;
    bif.cmt_i_pc          = v.pc;
    bif.cmt_i_imm         = v.imm;
    csr_epc_r             = v.epc;
    csr_dpc_r             = v.dpc;
    nonalu                = v.na;
    bif.brchmis_flush_ack = v.ack;
    perf_clr              = v.pclr;
  endtask

  // One clock: drive at edge+1, check mid-cycle, advance the model at the edge.
  task automatic cycle(input vec_t v, input bit use_tbl);
    logic rv32, bjp, prdt, rslv, fnc, mret, dret;
    logic bc, need, e_ready, e_req, hsk, acc;
    logic [2:0]  e_ena;
    logic [31:0] tgt;
    drive(v);
    #4;
    {rv32, bjp, prdt, rslv, fnc, mret, dret} = v.attr;
    bc      = bjp | fnc | mret | dret;
    need    = (bjp && prdt != rslv) || fnc || mret || dret;
    e_req   = m_pend && !v.na;
    e_ready = !m_pend && (!bc || !v.na);
    hsk     = e_req && v.ack;
    e_ena   = hsk ? m_kind : 3'b000;
    if (use_tbl) begin
      chk("tbl_ready", 32'(bif.cmt_i_ready), 32'(v.e_ready));
      chk("tbl_req",   32'(bif.brchmis_flush_req), 32'(v.e_req));
      chk("tbl_pc",    bif.brchmis_flush_pc, v.e_pc);
      chk("tbl_ena",   32'({bif.cmt_mret_ena, bif.cmt_dret_ena, bif.cmt_fencei_ena}), 32'(v.e_ena));
    end else begin
      chk("ready", 32'(bif.cmt_i_ready), 32'(e_ready));
      chk("req",   32'(bif.brchmis_flush_req), 32'(e_req));
      chk("pc",    bif.brchmis_flush_pc, m_fpc);
      chk("ena",   32'({bif.cmt_mret_ena, bif.cmt_dret_ena, bif.cmt_fencei_ena}), 32'(e_ena));
    end
    chk("perf_bjp", 32'(perf_bjp_cnt), 32'(m_bjp));
    chk("perf_mis", 32'(perf_mis_cnt), 32'(m_mis));

    if (!v.rst_n) begin
      m_pend = 0; m_fpc = '0; m_kind = '0; m_bjp = 0; m_mis = 0;
    end else begin
      acc = v.valid && e_ready;
      if (hsk) m_pend = 0;
      if (acc && need) begin
        if (dret)             tgt = v.dpc;
        else if (mret)        tgt = v.epc;
        else if (fnc || prdt) tgt = add32(v.pc, rv32 ? 32'd4 : 32'd2);
        else                  tgt = add32(v.pc, v.imm);
        m_pend = 1; m_fpc = tgt; m_kind = {mret, dret, fnc};
      end
      if (PERF) begin
        if (v.pclr) begin
          m_bjp = 0; m_mis = 0;
        end else if (acc && bjp) begin
          if (prdt == rslv) m_bjp = (m_bjp < CMAX) ? m_bjp + 1 : CMAX;
          else              m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    m_pend = 0; m_fpc = '0; m_kind = '0; m_bjp = 0; m_mis = 0;
    drive(mk(0, 0, A_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); @(posedge clk); #1;

    //          rst vld attr      pc            imm       epc      dpc      na ack  rdy req exp_pc        ena
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  1, 0, 0,            0));
    tbl.push_back(mk(1, 1, A_BR_MIS, 32'h80000100, 32'h40,   0,       0,       0, 0,  1, 0, 0,            0));
    tbl.push_back(mk(1, 1, A_ALU,    0,            0,        0,       0,       0, 0,  0, 1, 32'h80000140, 0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  0, 1, 32'h80000140, 0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 1,  0, 1, 32'h80000140, 0));
    tbl.push_back(mk(1, 1, A_ALU,    0,            0,        0,       0,       0, 0,  1, 0, 32'h80000140, 0));
    tbl.push_back(mk(1, 1, A_FNC16,  32'h200,      0,        0,       0,       0, 0,  1, 0, 32'h80000140, 0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  0, 1, 32'h202,      0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 1,  0, 1, 32'h202,      3'b001));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  1, 0, 32'h202,      0));
    tbl.push_back(mk(1, 1, A_MRET,   32'h40,       0,        32'h1000, 0,      0, 0,  1, 0, 32'h202,      0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        32'h2000, 0,      0, 0,  0, 1, 32'h1000,     0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        32'h2000, 0,      0, 1,  0, 1, 32'h1000,     3'b100));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        32'h2000, 0,      0, 0,  1, 0, 32'h1000,     0));
    tbl.push_back(mk(1, 1, A_DRET,   32'h80,       0,        0,       32'h3000, 0, 0, 1, 0, 32'h1000,     0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, A_NONE, 0,            0,        0,       0,       1, 1,  0, 0, 32'h3000,     0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 1,  0, 1, 32'h3000,     3'b010));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  1, 0, 32'h3000,     0));
    tbl.push_back(mk(1, 1, A_BR_MIS, 32'h700,      32'h8,    0,       0,       1, 0,  0, 0, 32'h3000,     0));
    tbl.push_back(mk(1, 1, A_ALU,    0,            0,        0,       0,       1, 0,  1, 0, 32'h3000,     0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  1, 0, 32'h3000,     0));
    tbl.push_back(mk(1, 1, A_BR_MIS, 32'hFFFFFFFE, 32'h4,    0,       0,       0, 0,  1, 0, 32'h3000,     0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  0, 1, 32'h2,        0));
    tbl.push_back(mk(0, 0, A_NONE,   0,            0,        0,       0,       0, 0,  0, 1, 32'h2,        0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  1, 0, 0,            0));
    tbl.push_back(mk(1, 1, A_BJP_OK, 32'h500,      32'h40,   0,       0,       0, 0,  1, 0, 0,            0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 0,  1, 0, 0,            0));
    tbl.push_back(mk(1, 1, A_BR_PMS, 32'h600,      32'h100,  0,       0,       0, 0,  1, 0, 0,            0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 1,  0, 1, 32'h604,      0));
    tbl.push_back(mk(1, 0, A_NONE,   0,            0,        0,       0,       0, 1,  1, 0, 32'h604,      0));

    foreach (tbl[i]) cycle(tbl[i], 1'b1);

    // Counter saturation, then clear colliding with a mispredict accept.
    cycle(mk(0, 0, A_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 20; i++)
      cycle(mk(1, 1, A_BJP_OK, 32'h1000 + 32'(i) * 4, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("perf_bjp_saturated", 32'(perf_bjp_cnt), PERF ? 32'hF : 32'h0);
    chk("perf_mis_after_ok",  32'(perf_mis_cnt), 32'h0);
    rv = mk(1, 1, A_BR_MIS, 32'h2000, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
    rv.pclr = 1'b1;
    cycle(rv, 1'b0);
    chk("perf_clr_bjp", 32'(perf_bjp_cnt), 32'h0);
    chk("perf_clr_mis", 32'(perf_mis_cnt), 32'h0);
    chk("perf_clr_req", 32'(bif.brchmis_flush_req), 32'h1);
    chk("perf_clr_pc",  bif.brchmis_flush_pc, 32'h2020);
    cycle(mk(1, 0, A_NONE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int cls;
      logic [6:0] a;
      cls = int'($urandom_range(0, 4));
      a   = '0;
      a[6] = 1'($urandom);
      case (cls)
        1: begin a[5] = 1'b1; a[4] = 1'($urandom); a[3] = 1'($urandom); end
        2: a[2] = 1'b1;
        3: a[1] = 1'b1;
        4: a[0] = 1'b1;
        default: ;
      endcase
      rv = mk(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), a,
              ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom,
              $urandom, $urandom, $urandom,
              ($urandom_range(0, 4) == 0), 1'($urandom), 0, 0, 0, 0);
      rv.pclr = ($urandom_range(0, 39) == 0);
      cycle(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
